led_pattern_gen: RTL and testbench

Pattern sequencer that sits directly upstream of the LED driver. It generates the `led_ctrl` bit vector and the `pwm_duty` brightness word from register-bank settings. It supports four modes: static, blink, ping-pong scan and breathing. Outputs are registered and drive the LED driver's `led_ctrl`/`pwm_duty` inputs without further glue.

---
 rtl/led_pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: static, blink, ping-pong scan and breathing modes.
// Registered outputs feed the LED driver's led_ctrl / pwm_duty inputs directly.
module led_pattern_gen #(
    parameter int NUM_LEDS       = 4,
    parameter int PWM_RESOLUTION = 8,
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int TICK_HZ        = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [NUM_LEDS-1:0]       pattern,
    input  logic [15:0]               period,
    input  logic [PWM_RESOLUTION-1:0] duty_max,
    output logic [NUM_LEDS-1:0]       led_ctrl,
    output logic [PWM_RESOLUTION-1:0] pwm_duty,
    output logic                      step_pulse
);
    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [PRE_W-1:0]          PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]          PRE_ONE  = PRE_W'(1);
    localparam logic [POS_W-1:0]          POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]          POS_ONE  = POS_W'(1);
    localparam logic [PWM_RESOLUTION-1:0] RAMP_ONE = PWM_RESOLUTION'(1);

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRE_W-1:0]          presc_q;
    logic                      tick;
    logic [15:0]               step_cnt_q, step_cnt_d, period_m1;
    mode_e                     mode_cur, mode_q;
    logic                      restart, step_evt;
    logic                      phase_q, phase_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    dir_e                      scan_dir_q, scan_dir_d;
    logic [PWM_RESOLUTION-1:0] ramp_q, ramp_d;
    dir_e                      ramp_dir_q, ramp_dir_d;
    logic [NUM_LEDS-1:0]       led_d;
    logic [PWM_RESOLUTION-1:0] duty_d;
    logic                      pulse_d;

    // Free-running prescaler, deliberately independent of enable and mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (presc_q == PRE_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_ONE;
        end
    end

    assign mode_cur  = mode_e'(mode);
    assign tick      = (presc_q == PRE_LAST);
    assign period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign restart   = !enable || (mode_cur != mode_q);
    assign step_evt  = tick && (step_cnt_q == period_m1) && !restart;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        step_cnt_d = step_cnt_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        scan_dir_d = scan_dir_q;
        ramp_d     = ramp_q;
        ramp_dir_d = ramp_dir_q;
        led_d      = '0;
        duty_d     = '0;
        pulse_d    = 1'b0;

        if (restart) begin
            step_cnt_d = '0;
            phase_d    = 1'b0;
            pos_d      = '0;
            scan_dir_d = DIR_UP;
            ramp_d     = '0;
            ramp_dir_d = DIR_UP;
        end else begin
            if (tick) begin
                step_cnt_d = step_evt ? 16'd0 : step_cnt_q + 16'd1;
            end
            if (step_evt) begin
                case (mode_cur)
                    MODE_BLINK: phase_d = !phase_q;
                    MODE_SCAN: begin
                        if (NUM_LEDS > 1) begin
                            if (scan_dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    scan_dir_d = DIR_DOWN;
                                    pos_d      = pos_q - POS_ONE;
                                end else begin
                                    pos_d = pos_q + POS_ONE;
                                end
                            end else if (pos_q == '0) begin
                                scan_dir_d = DIR_UP;
                                pos_d      = pos_q + POS_ONE;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        // Comparing against the live duty_max lets a lowered peak turn the ramp around.
                        if (ramp_dir_q == DIR_UP) begin
                            if (ramp_q < duty_max) begin
                                ramp_d = ramp_q + RAMP_ONE;
                            end else begin
                                ramp_dir_d = DIR_DOWN;
                                ramp_d     = (ramp_q == '0) ? '0 : ramp_q - RAMP_ONE;
                            end
                        end else if (ramp_q != '0) begin
                            ramp_d = ramp_q - RAMP_ONE;
                        end else begin
                            ramp_dir_d = DIR_UP;
                            ramp_d     = (duty_max != '0) ? RAMP_ONE : '0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (enable) begin
            case (mode_cur)
                MODE_STATIC: begin
                    led_d  = pattern;
                    duty_d = duty_max;
                end
                MODE_BLINK: begin
                    led_d  = phase_d ? pattern : '0;
                    duty_d = duty_max;
                end
                MODE_SCAN: begin
                    led_d  = NUM_LEDS'(1) << pos_d;
                    duty_d = duty_max;
                end
                MODE_BREATHE: begin
                    led_d  = pattern;
                    duty_d = (ramp_d < duty_max) ? ramp_d : duty_max;
                end
            endcase
            pulse_d = step_evt && (mode_cur != MODE_STATIC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q <= '0;
            phase_q    <= 1'b0;
            pos_q      <= '0;
            scan_dir_q <= DIR_UP;
            ramp_q     <= '0;
            ramp_dir_q <= DIR_UP;
            mode_q     <= MODE_STATIC;
            led_ctrl   <= '0;
            pwm_duty   <= '0;
            step_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            step_cnt_q <= step_cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            scan_dir_q <= scan_dir_d;
            ramp_q     <= ramp_d;
            ramp_dir_q <= ramp_dir_d;
            mode_q     <= mode_cur;
            led_ctrl   <= led_d;
            pwm_duty   <= duty_d;
            step_pulse <= pulse_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: per-cycle scoreboard fed by an abstract
// timing/sequence model, plus directed checks of the published sequences.
module tb_led_pattern_gen;
    localparam int NUM_LEDS = 4;
    localparam int PWM_W    = 8;
    localparam int TICK_DIV = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable;
    logic [1:0]         mode;
    logic [NUM_LEDS-1:0] pattern;
    logic [15:0]        period;
    logic [PWM_W-1:0]   duty_max;
    logic [NUM_LEDS-1:0] led_ctrl;
    logic [PWM_W-1:0]   pwm_duty;
    logic               step_pulse;

    led_pattern_gen #(
        .NUM_LEDS      (NUM_LEDS),
        .PWM_RESOLUTION(PWM_W),
        .CLK_FREQ_HZ   (100),
        .TICK_HZ       (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .pattern   (pattern),
        .period    (period),
        .duty_max  (duty_max),
        .led_ctrl  (led_ctrl),
        .pwm_duty  (pwm_duty),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_LEDS-1:0] led;
        logic [PWM_W-1:0]    duty;
        logic                pulse;
    } out_t;

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [NUM_LEDS-1:0] cap_led[$];
    logic [PWM_W-1:0]    cap_duty[$];
    int                  cap_cyc[$];

    logic [NUM_LEDS-1:0] scan_tab[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [PWM_W-1:0]    breathe_tab[7] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset gives the prescaler phase, ticks since
    // restart give the step count, and the step count gives blink/scan state.
    int   m_edges, m_ticks, m_steps, m_ramp;
    bit   m_rdown;
    logic [1:0] m_prev_mode;

    function automatic int tri_pos(input int k);
        int l, r;
        if (NUM_LEDS == 1) return 0;
        l = 2 * (NUM_LEDS - 1);
        r = k % l;
        return (r < NUM_LEDS) ? r : l - r;
    endfunction

    function automatic void breathe_step(input int dmax);
        if (!m_rdown) begin
            if (m_ramp < dmax) m_ramp++;
            else begin
                m_rdown = 1'b1;
                if (m_ramp > 0) m_ramp--;
            end
        end else begin
            if (m_ramp > 0) m_ramp--;
            else begin
                m_rdown = 1'b0;
                if (dmax > 0) m_ramp++;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model
        out_t e;
        bit   tick_m, restart_m, step_m;
        int   p;
        e      = '0;
        step_m = 1'b0;
        if (rst) begin
            m_edges     = 0;
            m_ticks     = 0;
            m_steps     = 0;
            m_ramp      = 0;
            m_rdown     = 1'b0;
            m_prev_mode = 2'd0;
        end else begin
            tick_m = (m_edges % TICK_DIV) == (TICK_DIV - 1);
            m_edges++;
            p = (period == 16'd0) ? 1 : int'(period);
            restart_m = !enable || (mode != m_prev_mode);
            m_prev_mode = mode;
            if (restart_m) begin
                m_ticks = 0;
                m_steps = 0;
                m_ramp  = 0;
                m_rdown = 1'b0;
            end else if (tick_m) begin
                m_ticks++;
                if (m_ticks % p == 0) begin
                    step_m = 1'b1;
                    m_steps++;
                    if (mode == 2'd3) breathe_step(int'(duty_max));
                end
            end
            if (enable) begin
                case (mode)
                    2'd0: begin e.led = pattern; e.duty = duty_max; end
                    2'd1: begin e.led = (m_steps % 2 == 1) ? pattern : '0; e.duty = duty_max; end
                    2'd2: begin e.led = NUM_LEDS'(1 << tri_pos(m_steps)); e.duty = duty_max; end
                    default: begin
                        e.led  = pattern;
                        e.duty = PWM_W'((m_ramp < int'(duty_max)) ? m_ramp : int'(duty_max));
                    end
                endcase
                e.pulse = step_m && (mode != 2'd0);
            end
        end
        exp_q.push_back(e);
    end

    always @(posedge clk or posedge rst) begin : monitor
        out_t e;
        #1;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_led", 32'(led_ctrl), 32'(e.led));
            check("sb_duty", 32'(pwm_duty), 32'(e.duty));
            check("sb_pulse", 32'(step_pulse), 32'(e.pulse));
        end
    end

    task automatic wait_pulses(input int n, input int budget);
        int b = budget;
        cap_led.delete();
        cap_duty.delete();
        cap_cyc.delete();
        while (cap_led.size() < n && b > 0) begin
            @(negedge clk);
            b--;
            if (step_pulse) begin
                cap_led.push_back(led_ctrl);
                cap_duty.push_back(pwm_duty);
                cap_cyc.push_back(cyc);
            end
        end
        check("pulse_budget", 32'(cap_led.size()), 32'(n));
    endtask

    task automatic check_gaps(input int gap);
        for (int i = 1; i < cap_cyc.size(); i++)
            check("step_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'(gap));
    endtask

    task automatic check_scan_table();
        for (int i = 0; i < cap_led.size() && i < 7; i++)
            check("scan_seq", 32'(cap_led[i]), 32'(scan_tab[i]));
    endtask

    initial begin
        enable   = 1'b1;
        mode     = 2'd0;
        pattern  = '0;
        period   = 16'd1;
        duty_max = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-SCAN clears outputs immediately, then STATIC follows one edge later.
        mode = 2'd2; duty_max = 8'd50; period = 16'd1;
        wait_pulses(3, 100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_led", 32'(led_ctrl), 32'd0);
        check("rst_duty", 32'(pwm_duty), 32'd0);
        check("rst_pulse", 32'(step_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0; mode = 2'd0; pattern = 4'b1010; duty_max = 8'd200;
        @(negedge clk);
        check("static_led", 32'(led_ctrl), 32'b1010);
        check("static_duty", 32'(pwm_duty), 32'd200);

        // BLINK, period 3.
        mode = 2'd1; period = 16'd3; pattern = 4'b0110;
        wait_pulses(4, 200);
        for (int i = 0; i < cap_led.size(); i++)
            check("blink_led", 32'(cap_led[i]), (i % 2 == 0) ? 32'b0110 : 32'd0);
        check_gaps(30);

        // SCAN with period 1, then identical with period 0.
        mode = 2'd2; period = 16'd1;
        @(negedge clk);
        check("scan_start", 32'(led_ctrl), 32'b0001);
        wait_pulses(7, 200);
        check_scan_table();
        check_gaps(10);
        enable = 1'b0; period = 16'd0;
        @(negedge clk);
        check("disable_led", 32'(led_ctrl), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("scan_p0_start", 32'(led_ctrl), 32'b0001);
        wait_pulses(7, 200);
        check_scan_table();
        check_gaps(10);

        // BREATHE with peak 3, then a mid-ramp drop of the peak.
        mode = 2'd3; duty_max = 8'd3; period = 16'd1; pattern = 4'b1001;
        @(negedge clk);
        check("breathe_start", 32'(pwm_duty), 32'd0);
        wait_pulses(7, 200);
        for (int i = 0; i < cap_duty.size() && i < 7; i++) begin
            check("breathe_duty", 32'(cap_duty[i]), 32'(breathe_tab[i]));
            check("breathe_led", 32'(cap_led[i]), 32'b1001);
        end
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_pulses(3, 100);
        check("ramp_top", (cap_duty.size() == 3) ? 32'(cap_duty[2]) : 32'hFFFF, 32'd3);
        duty_max = 8'd1;
        @(negedge clk);
        check("clamp_now", 32'(pwm_duty), 32'd1);
        wait_pulses(3, 100);
        for (int i = 0; i < cap_duty.size(); i++)
            check("ramp_descend", 32'(cap_duty[i]), (i < 2) ? 32'd1 : 32'd0);

        // Restart on mode switch and on disable.
        mode = 2'd2; duty_max = 8'd80;
        wait_pulses(2, 100);
        check("scan_pos2", (cap_led.size() == 2) ? 32'(cap_led[1]) : 32'hFFFF, 32'b0100);
        mode = 2'd1;
        @(negedge clk);
        check("blink_restart", 32'(led_ctrl), 32'd0);
        mode = 2'd2;
        @(negedge clk);
        check("scan_restart", 32'(led_ctrl), 32'b0001);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("off_led", 32'(led_ctrl), 32'd0);
            check("off_duty", 32'(pwm_duty), 32'd0);
            check("off_pulse", 32'(step_pulse), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("reenable_led", 32'(led_ctrl), 32'b0001);
        wait_pulses(2, 100);
        check_scan_table();

        // BREATHE with zero peak: output stays 0 while steps keep firing.
        mode = 2'd3; duty_max = 8'd0; period = 16'd1;
        wait_pulses(20, 400);
        for (int i = 0; i < cap_duty.size(); i++)
            check("zero_peak_duty", 32'(cap_duty[i]), 32'd0);
        check_gaps(10);
        enable = 1'b0; period = 16'd2;
        @(negedge clk);
        enable = 1'b1;
        wait_pulses(4, 200);
        check_gaps(20);

        // Randomized traffic, checked by the scoreboard.
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: begin
                    mode   = mode + 2'($urandom_range(1, 3));
                    period = 16'($urandom_range(0, 3));
                end
                1: pattern  = NUM_LEDS'($urandom);
                2: duty_max = PWM_W'($urandom_range(0, 6));
                default: begin
                    enable = 1'b0;
                    period = 16'($urandom_range(0, 3));
                    @(negedge clk);
                    enable = 1'b1;
                end
            endcase
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
